sipo_deserializer: RTL

Serial-in, parallel-out front-end stage that directly feeds the 4-bit PIPO output register.
- Shifts in one serial bit per enabled clock and counts bits.
- After WIDTH bits, presents the assembled word on Po with a valid/ack handshake.
- Flags an overrun when a new word completes before the previous one is acknowledged.

---
 rtl/sipo_deserializer_pkg.sv | 13 +
 rtl/sipo_deserializer_bit_counter.sv | 46 ++++
 rtl/sipo_deserializer.sv | 98 +++++++++
 3 files changed

// File: rtl/sipo_deserializer_pkg.sv
// Shared constants for the serial-to-parallel front end feeding the 4-bit PIPO register.
package sipo_deserializer_pkg;

  // Must match the downstream PIPO word width.
  localparam int DEFAULT_WIDTH = 4;

  localparam bit MSB_FIRST_ORDER = 1'b1;
  localparam bit LSB_FIRST_ORDER = 1'b0;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

endpackage : sipo_deserializer_pkg

// File: rtl/sipo_deserializer_bit_counter.sv
// Modulo-WIDTH bit counter with enable, synchronous clear and terminal-count flag.
module sipo_deserializer_bit_counter
  import sipo_deserializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Terminal count is taken from the registered value so it never depends on inputs.
  assign tc  = (cnt_q == LAST);
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (tc) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : sipo_deserializer_bit_counter

// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer with valid/ack output handshake and sticky overrun flag.
module sipo_deserializer
  import sipo_deserializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = MSB_FIRST_ORDER,
  localparam int CNT_W    = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Si,
  input  logic             Si_en,
  input  logic             Flush,
  input  logic             Po_ack,
  output logic [WIDTH-1:0] Po,
  output logic             Po_valid,
  output logic             Overrun,
  output logic [CNT_W-1:0] Bit_cnt
);

  logic [WIDTH-1:0] sh_d,  sh_q;
  logic [WIDTH-1:0] po_d,  po_q;
  logic             po_valid_d, po_valid_q;
  logic             overrun_d,  overrun_q;

  logic [WIDTH-1:0] sh_shifted;
  logic             shift_en;
  logic             last_bit;
  logic             complete;

  // Flush wins over Si_en: the bit on a flush edge is discarded.
  assign shift_en = Si_en & ~Flush;
  assign complete = shift_en & last_bit;

  sipo_deserializer_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .Clk (Clk),
    .Rst (Rst),
    .en  (shift_en),
    .clr (Flush),
    .cnt (Bit_cnt),
    .tc  (last_bit)
  );

  always_comb begin
    sh_shifted = sh_q;
    if (MSB_FIRST) begin
      sh_shifted = {sh_q[WIDTH-2:0], Si};
    end else begin
      sh_shifted = {Si, sh_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    sh_d       = sh_q;
    po_d       = po_q;
    po_valid_d = po_valid_q;
    overrun_d  = overrun_q;

    if (Flush) begin
      sh_d = '0;
    end else if (shift_en) begin
      sh_d = sh_shifted;
    end

    // A completion on the same edge as an ack replaces the consumed word cleanly.
    if (complete) begin
      po_d       = sh_shifted;
      po_valid_d = 1'b1;
      if (po_valid_q && !Po_ack) begin
        overrun_d = 1'b1;
      end
    end else if (Po_ack) begin
      po_valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sh_q       <= '0;
      po_q       <= '0;
      po_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sh_q       <= sh_d;
      po_q       <= po_d;
      po_valid_q <= po_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign Po       = po_q;
  assign Po_valid = po_valid_q;
  assign Overrun  = overrun_q;

endmodule : sipo_deserializer
